t_state_control_unit: RTL and testbench

- Consumer end of the six-phase ring sequencer: takes the one-hot T-state pulses seq1..seq6 plus the instruction-register opcode, and produces the registered control word that drives the PC, MAR, RAM, IR, A/B, ALU and output registers.
- Also holds the halt latch, an instruction-retired counter, and an optional T-state order checker.

---
 rtl/cpu_ctrl_pkg.sv | 42 ++++
 rtl/t_state_control_unit_if.sv | 20 ++
 rtl/t_state_control_unit_cw_decode.sv | 66 ++++++
 rtl/t_state_control_unit.sv | 91 +++++++++
 tb/tb_t_state_control_unit.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the T-state control unit: opcodes, control-word bit positions, T-state indices.
// Pure declarations, no latency; no flow control.
// Optional order checker is enabled elsewhere with SEQ_CHECK_EN.
package cpu_ctrl_pkg;

    localparam int CW_BITS = 12;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_LM = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;

    // Position of the highest set bit; only meaningful when seq is one-hot.
    function automatic logic [2:0] seq_idx(input logic [5:0] seq);
        seq_idx = '0;
        for (int i = 0; i < 6; i++) begin
            if (seq[i]) seq_idx = 3'(i);
        end
    endfunction

endpackage

// File: rtl/t_state_control_unit_if.sv
// Sequencer-to-control-unit bundle: T-state pulses and opcode in, control word and status out.
// No latency of its own; no backpressure, the sequencer is gated by halt instead.
// seq_err is only driven meaningfully when SEQ_CHECK_EN is defined.
interface t_state_control_unit_if #(
    parameter int OP_W  = 4,
    parameter int CNT_W = 8,
    parameter int CW_W  = 12
);
    logic [5:0]       seq;
    logic [OP_W-1:0]  opcode;
    logic [CW_W-1:0]  cw;
    logic             halt;
    logic [CNT_W-1:0] instr_cnt;
    logic             seq_err;

    modport master (output seq, output opcode,
                    input  cw, input halt, input instr_cnt, input seq_err);
    modport slave  (input  seq, input opcode,
                    output cw, output halt, output instr_cnt, output seq_err);
endinterface

// File: rtl/t_state_control_unit_cw_decode.sv
// Combinational T-state/opcode to control-word decode (cw_decode).
// Zero latency; no backpressure. Non-one-hot or all-zero seq decodes to an empty word.
// Unaffected by SEQ_CHECK_EN.
module cw_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [5:0]         seq,
    input  logic [OP_W-1:0]    opcode_sel,
    output logic [CW_BITS-1:0] cw_next
);

    always_comb begin
        cw_next = '0;
        if ($onehot(seq)) begin
            if (seq[T1]) begin
                cw_next[CW_EP] = 1'b1;
                cw_next[CW_LM] = 1'b1;
            end else if (seq[T2]) begin
                cw_next[CW_CP] = 1'b1;
            end else if (seq[T3]) begin
                cw_next[CW_CE] = 1'b1;
                cw_next[CW_LI] = 1'b1;
            end else if (seq[T4]) begin
                case (opcode_sel)
                    OP_W'(OP_LDA), OP_W'(OP_ADD), OP_W'(OP_SUB): begin
                        cw_next[CW_EI] = 1'b1;
                        cw_next[CW_LM] = 1'b1;
                    end
                    OP_W'(OP_OUT): begin
                        cw_next[CW_EA] = 1'b1;
                        cw_next[CW_LO] = 1'b1;
                    end
                    default: ;
                endcase
            end else if (seq[T5]) begin
                case (opcode_sel)
                    OP_W'(OP_LDA): begin
                        cw_next[CW_CE] = 1'b1;
                        cw_next[CW_LA] = 1'b1;
                    end
                    OP_W'(OP_ADD), OP_W'(OP_SUB): begin
                        cw_next[CW_CE] = 1'b1;
                        cw_next[CW_LB] = 1'b1;
                    end
                    default: ;
                endcase
            end else begin
                case (opcode_sel)
                    OP_W'(OP_ADD): begin
                        cw_next[CW_EU] = 1'b1;
                        cw_next[CW_LA] = 1'b1;
                    end
                    OP_W'(OP_SUB): begin
                        cw_next[CW_SU] = 1'b1;
                        cw_next[CW_EU] = 1'b1;
                        cw_next[CW_LA] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/t_state_control_unit.sv
// Registered control word, halt latch, retired-instruction counter; SEQ_CHECK_EN adds a T-state order checker.
// Latency: cw/halt/instr_cnt/seq_err reflect the seq/opcode sampled one rising edge earlier.
// No backpressure: halt is the only throttle, the sequencer gates its own clock with it.
module t_state_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W  = 4,
    parameter int CNT_W = 8,
    parameter int CW_W  = 12
) (
    input  logic                   dummy_clk,
    input  logic                   FPGA_rst_n,
    t_state_control_unit_if.slave  ctl
);

    logic [CW_W-1:0]  cw_q, cw_d, dec_cw;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OP_W-1:0]  op_q, op_d, op_sel;
    logic             seq_onehot;

    // T4 must see the opcode the same cycle IR is being loaded, hence the bypass.
    assign op_sel = ctl.seq[T4] ? ctl.opcode : op_q;

    cw_decode #(.OP_W(OP_W)) u_cw_decode (
        .seq        (ctl.seq),
        .opcode_sel (op_sel),
        .cw_next    (dec_cw)
    );

    always_comb begin
        seq_onehot = $onehot(ctl.seq);
        cw_d       = halt_q ? '0 : dec_cw;
        halt_d     = halt_q | (seq_onehot & ctl.seq[T4] & (ctl.opcode == OP_W'(OP_HLT)));
        op_d       = ctl.seq[T4] ? ctl.opcode : op_q;
        cnt_d      = (ctl.seq[T6] && !halt_q) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge dummy_clk or negedge FPGA_rst_n) begin
        if (!FPGA_rst_n) begin
            cw_q   <= '0;
            halt_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= '0;
        end else begin
            cw_q   <= cw_d;
            halt_q <= halt_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
        end
    end

    assign ctl.cw        = cw_q;
    assign ctl.halt      = halt_q;
    assign ctl.instr_cnt = cnt_q;

`ifdef SEQ_CHECK_EN
    logic [2:0] exp_idx_q, exp_idx_d, cur_idx;
    logic       seq_err_q, seq_err_d;

    // A malformed pulse flags an error but gives no index to resync to.
    always_comb begin
        cur_idx   = seq_idx(ctl.seq);
        seq_err_d = seq_err_q;
        exp_idx_d = exp_idx_q;
        if (ctl.seq != '0) begin
            if (!seq_onehot) begin
                seq_err_d = 1'b1;
            end else begin
                if (cur_idx != exp_idx_q) seq_err_d = 1'b1;
                exp_idx_d = (cur_idx == 3'd5) ? 3'd0 : cur_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge dummy_clk or negedge FPGA_rst_n) begin
        if (!FPGA_rst_n) begin
            exp_idx_q <= '0;
            seq_err_q <= 1'b0;
        end else begin
            exp_idx_q <= exp_idx_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign ctl.seq_err = seq_err_q;
`else
    assign ctl.seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_t_state_control_unit.sv
// Bench for t_state_control_unit: directed phase walks plus randomized seq/opcode traffic
// compared against an instruction-level reference model. Honours SEQ_CHECK_EN.
module tb_t_state_control_unit;

    logic dummy_clk = 1'b0;
    logic FPGA_rst_n = 1'b1;
    always #5 dummy_clk = ~dummy_clk;

    t_state_control_unit_if #(.OP_W(4), .CNT_W(8), .CW_W(12)) bus ();

    t_state_control_unit #(.OP_W(4), .CNT_W(8), .CW_W(12)) dut (
        .dummy_clk  (dummy_clk),
        .FPGA_rst_n (FPGA_rst_n),
        .ctl        (bus)
    );

    localparam logic [11:0] M_CP = 12'h800, M_EP = 12'h400, M_LM = 12'h200, M_CE = 12'h100;
    localparam logic [11:0] M_LI = 12'h080, M_EI = 12'h040, M_LA = 12'h020, M_EA = 12'h010;
    localparam logic [11:0] M_SU = 12'h008, M_EU = 12'h004, M_LB = 12'h002, M_LO = 12'h001;

    int checks = 0;
    int errors = 0;

    logic [11:0] m_cw;
    bit          m_halt;
    int          m_cnt;
    logic [3:0]  m_op;
    bit          m_err;
    int          m_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Micro-steps of each instruction, t = 1..6.
    function automatic logic [11:0] ref_cw(input int t, input logic [3:0] op);
        logic [11:0] r;
        r = 12'h000;
        case (t)
            1: r = M_EP | M_LM;
            2: r = M_CP;
            3: r = M_CE | M_LI;
            default: begin
                case (op)
                    4'h0: r = (t == 4) ? (M_EI | M_LM) : (t == 5) ? (M_CE | M_LA) : 12'h000;
                    4'h1: r = (t == 4) ? (M_EI | M_LM) : (t == 5) ? (M_CE | M_LB) : (M_EU | M_LA);
                    4'h2: r = (t == 4) ? (M_EI | M_LM) : (t == 5) ? (M_CE | M_LB) : (M_SU | M_EU | M_LA);
                    4'hE: r = (t == 4) ? (M_EA | M_LO) : 12'h000;
                    default: r = 12'h000;
                endcase
            end
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_cw = '0; m_halt = 0; m_cnt = 0; m_op = '0; m_err = 0; m_exp = 0;
    endtask

    task automatic model_edge(input logic [5:0] s, input logic [3:0] op);
        int ones;
        int idx;
        bit nh;
        ones = $countones(s);
        idx  = 0;
        for (int i = 0; i < 6; i++) if (s[i]) idx = i;
        if (m_halt || ones != 1) m_cw = '0;
        else m_cw = ref_cw(idx + 1, (idx == 3) ? op : m_op);
        nh = m_halt || (ones == 1 && idx == 3 && op == 4'hF);
        if (s[5] && !m_halt) m_cnt = (m_cnt + 1) % 256;
        if (s[3]) m_op = op;
        if (ones > 1) m_err = 1;
        else if (ones == 1) begin
            if (idx != m_exp) m_err = 1;
            m_exp = (idx + 1) % 6;
        end
        m_halt = nh;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_cw"}, 32'(bus.cw), 32'(m_cw));
        chk({tag, "_halt"}, 32'(bus.halt), 32'(m_halt));
        chk({tag, "_cnt"}, 32'(bus.instr_cnt), 32'(m_cnt));
`ifdef SEQ_CHECK_EN
        chk({tag, "_err"}, 32'(bus.seq_err), 32'(m_err));
`else
        chk({tag, "_err"}, 32'(bus.seq_err), 32'(0));
`endif
    endtask

    task automatic step(input logic [5:0] s, input logic [3:0] op, input string tag);
        @(negedge dummy_clk);
        bus.seq = s;
        bus.opcode = op;
        @(posedge dummy_clk);
        model_edge(s, op);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        #2;
        FPGA_rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_cw", 32'(bus.cw), 32'(0));
        chk("rst_halt", 32'(bus.halt), 32'(0));
        chk("rst_cnt", 32'(bus.instr_cnt), 32'(0));
        chk("rst_err", 32'(bus.seq_err), 32'(0));
        @(negedge dummy_clk);
        bus.seq = '0;
        FPGA_rst_n = 1'b1;
    endtask

    task automatic run_instr(input logic [3:0] op, input string tag);
        for (int t = 0; t < 6; t++) step(6'(1 << t), op, tag);
    endtask

    logic [3:0] rop;
    int phase;
    int r;

    initial begin
        bus.seq = '0;
        bus.opcode = '0;
        do_reset();

        step(6'b000001, 4'h0, "lda_t1"); chk("lda_t1_lit", 32'(bus.cw), 32'h600);
        step(6'b000010, 4'h0, "lda_t2"); chk("lda_t2_lit", 32'(bus.cw), 32'h800);
        step(6'b000100, 4'h0, "lda_t3"); chk("lda_t3_lit", 32'(bus.cw), 32'h180);
        step(6'b001000, 4'h0, "lda_t4"); chk("lda_t4_lit", 32'(bus.cw), 32'h240);
        step(6'b010000, 4'h0, "lda_t5"); chk("lda_t5_lit", 32'(bus.cw), 32'h120);
        step(6'b100000, 4'h0, "lda_t6"); chk("lda_t6_lit", 32'(bus.cw), 32'h000);
        chk("lda_cnt_lit", 32'(bus.instr_cnt), 32'd1);

        run_instr(4'h2, "sub");
        chk("sub_t6_lit", 32'(bus.cw), 32'h02C);
        run_instr(4'h1, "add");
        chk("add_t6_lit", 32'(bus.cw), 32'h024);

        // Opcode flips to HLT after T4: op_q must keep the ADD decode.
        step(6'b000001, 4'h1, "hold_t1");
        step(6'b000010, 4'h1, "hold_t2");
        step(6'b000100, 4'h1, "hold_t3");
        step(6'b001000, 4'h1, "hold_t4");
        step(6'b010000, 4'hF, "hold_t5"); chk("hold_t5_lit", 32'(bus.cw), 32'h102);
        step(6'b100000, 4'hF, "hold_t6"); chk("hold_t6_lit", 32'(bus.cw), 32'h024);
        chk("hold_halt_lit", 32'(bus.halt), 32'd0);

        do_reset();
        run_instr(4'hE, "out");
        step(6'b000001, 4'hF, "hlt_t1");
        step(6'b000010, 4'hF, "hlt_t2");
        step(6'b000100, 4'hF, "hlt_t3");
        step(6'b001000, 4'hF, "hlt_t4");
        chk("hlt_halt_lit", 32'(bus.halt), 32'd1);
        chk("hlt_cw_lit", 32'(bus.cw), 32'h000);
        step(6'b010000, 4'hF, "hlt_t5");
        step(6'b100000, 4'hF, "hlt_t6");
        run_instr(4'h1, "halted");
        chk("halted_cnt_lit", 32'(bus.instr_cnt), 32'd1);
        chk("halted_cw_lit", 32'(bus.cw), 32'h000);

        do_reset();
        for (int i = 0; i < 256; i++) run_instr(4'h0, "wrap");
        chk("wrap_cnt_lit", 32'(bus.instr_cnt), 32'd0);
        run_instr(4'h0, "wrap1");
        chk("wrap1_cnt_lit", 32'(bus.instr_cnt), 32'd1);

`ifdef SEQ_CHECK_EN
        do_reset();
        step(6'b000001, 4'h0, "skip_t1");
        step(6'b000100, 4'h0, "skip_t3");
        chk("skip_err_lit", 32'(bus.seq_err), 32'd1);
        do_reset();
        step(6'b000011, 4'h0, "multi");
        chk("multi_err_lit", 32'(bus.seq_err), 32'd1);
        chk("multi_cw_lit", 32'(bus.cw), 32'h000);
`endif

        // Reset in the middle of T5, then resume with op_q back at LDA.
        do_reset();
        for (int t = 0; t < 5; t++) step(6'(1 << t), 4'h1, "mid");
        do_reset();
        step(6'b010000, 4'h1, "after_t5");
        chk("after_t5_lit", 32'(bus.cw), 32'h120);

        do_reset();
        phase = 0;
        rop = 4'h0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 30) begin
                r = $urandom_range(0, 99);
                if (r < 25)      rop = 4'h0;
                else if (r < 45) rop = 4'h1;
                else if (r < 65) rop = 4'h2;
                else if (r < 75) rop = 4'hE;
                else if (r < 78) rop = 4'hF;
                else             rop = 4'($urandom_range(0, 15));
            end
            r = $urandom_range(0, 99);
            if (r < 80) begin
                step(6'(1 << phase), rop, "rnd");
                phase = (phase + 1) % 6;
            end else if (r < 88) begin
                step(6'b000000, rop, "rnd_zero");
            end else if (r < 94) begin
                step(6'($urandom_range(0, 63)), rop, "rnd_any");
            end else begin
                phase = $urandom_range(0, 5);
                step(6'(1 << phase), rop, "rnd_jump");
                phase = (phase + 1) % 6;
            end
            if ((m_halt && $urandom_range(0, 19) == 0) || $urandom_range(0, 299) == 0) begin
                do_reset();
                phase = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
